simple_bfm_sink: RTL and testbench
==================================

Name: simple_bfm_sink

Overview:
Downstream responder for the simple request BFM. It consumes the registered req/data handshake, returns a one-cycle ack after a programmable delay, and buffers each accepted byte in a small first-word-fall-through FIFO. A valid/ready drain port presents the buffered bytes to a checker or to the next stage. Back-pressure is applied by withholding ack while the FIFO is full.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, 4, width of ack_delay and of the internal delay counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  1  request from the upstream BFM; registered upstream, held until acked.
data  input  8  request payload; stable while req is high.
ack  output  1  registered one-cycle acknowledge pulse.
ack_delay  input  CNT_W  extra wait cycles before ack; sampled when a request is accepted for service.
out_valid  output  1  FIFO non-empty.
out_data  output  8  FIFO head; valid while out_valid is high.
out_ready  input  1  drain-side ready.
count  output  $clog2(DEPTH)+1  current FIFO occupancy.
proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n.
  - Reset values: ack=0, out_valid=0, count=0, proto_err=0, FSM in IDLE, FIFO pointers at 0.
  - Reset mid-handshake drops the pending beat. No push occurs.
- FSM states: IDLE, WAIT, ACK, HOLD. ack is high only in state ACK.
- IDLE:
  - If req=1 and count<DEPTH at an edge, load cnt=ack_delay.
  - Next state is ACK if ack_delay==0, otherwise WAIT.
  - If req=1 and the FIFO is full, remain in IDLE with ack=0. This is back-pressure.
- WAIT:
  - cnt decrements at each edge. When cnt==1 at an edge, go to ACK.
  - If req is sampled 0 while in WAIT, set proto_err and return to IDLE.
- ACK:
  - The transfer edge is the next edge, where ack=1 and req is sampled.
  - If req=1 at that edge, push data into the FIFO.
  - If req=0 at that edge, set proto_err and do not push.
  - Go to HOLD in either case.
- HOLD:
  - req is ignored for one cycle, because upstream deasserts req on the transfer edge.
  - Go to IDLE.
- Latency: req is first sampled high at edge E1. ack is high in the cycle after edge E1+ack_delay. The transfer edge is E2+ack_delay. The minimum spacing between accepted beats is 3 cycles (IDLE, ACK, HOLD).
- Space guarantee: the fullness check happens only in IDLE. No other push source exists, so space reserved at IDLE is guaranteed at the transfer edge, even when pops occur in between.
- FIFO:
  - A pop occurs on out_valid && out_ready at an edge.
  - Push and pop at the same edge are both performed; count is unchanged.
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - count saturates by construction: no push when full, no pop when empty.
  - out_data is the registered head entry, updated the same edge as the pointer. It is undefined when out_valid=0; the bench checks it only when out_valid=1.
- proto_err: set by the conditions above; cleared only by reset.
- ack_delay changes: a change while in WAIT or ACK does not affect the current beat.

Test Plan:
- ack_delay=0, single req with data=0xA5: ack pulses exactly one cycle, 1 cycle after req is sampled. out_valid rises after the transfer edge with out_data=0xA5, and count=1.
- ack_delay=3, back-to-back reqs 0x01..0x03 with out_ready=1: each ack follows req sampling by 4 cycles. Bytes drain in order 0x01, 0x02, 0x03; proto_err=0.
- out_ready=0, DEPTH=4, six reqs 0x10..0x15: four acks are issued, then ack stays 0 with count=4. Raising out_ready drains 0x10..0x13, after which 0x14 and 0x15 are acked and delivered in order.
- req dropped during WAIT (ack_delay=5, req low after 2 cycles): no ack, no push, proto_err=1 and stays 1 until rst_n is asserted.
- rst_n asserted while in ACK with count=2: ack, out_valid and count go to 0 immediately (asynchronously). After release, a new req 0x7E is accepted normally.
- Simultaneous push and pop at count=1 with out_ready held high: count stays 1, and head order is preserved across pointer wrap over 10 beats.

Source files
------------

// File: rtl/simple_bfm_sink_if.sv
// Handshake and drain-side bundle for simple_bfm_sink.
// The upstream BFM and drain checker use the master view; the sink uses the slave view.
interface simple_bfm_sink_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             req;
  logic [7:0]       data;
  logic             ack;
  logic [CNT_W-1:0] ack_delay;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             proto_err;

  modport master (
    output req, data, ack_delay, out_ready,
    input  ack, out_valid, out_data, count, proto_err
  );

  modport slave (
    input  req, data, ack_delay, out_ready,
    output ack, out_valid, out_data, count, proto_err
  );
endinterface

// File: rtl/simple_bfm_sink.sv
// Downstream responder: acks each req after ack_delay cycles and queues the
// accepted byte in a first-word-fall-through FIFO drained over valid/ready.
module simple_bfm_sink #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  simple_bfm_sink_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ack;
  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full, w_push, w_pop;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && bus.out_ready;

  // Space is reserved only in IDLE; the single push site in ACK can then never overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req && !w_full) begin
          w_cnt_nxt   = bus.ack_delay;
          w_state_nxt = (bus.ack_delay == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!bus.req) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ACK: begin
        w_push      = bus.req;
        w_err_nxt   = r_err | ~bus.req;
        w_state_nxt = HOLD;
      end
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_ack   <= (w_state_nxt == ACK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data;
  end

  assign bus.ack       = r_ack;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.proto_err = r_err;
endmodule

// File: tb/tb_simple_bfm_sink.sv
// Directed bench for simple_bfm_sink: a timestamp-based transaction model is
// compared every cycle, plus literal expectations per scenario.
module tb_simple_bfm_sink;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  simple_bfm_sink_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();
  simple_bfm_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a beat accepted at edge n with delay d has ack high after edge n+d,
  // transfers at edge n+d+1, and frees the responder after edge n+d+2.
  byte unsigned mq[$];
  bit m_busy, m_err;
  int m_acc, m_d, edge_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 0;
      m_err  = 0;
    end else begin
      bit pop, push;
      int k;
      edge_n++;
      pop  = (mq.size() > 0) && bus.out_ready;
      push = 0;
      if (!m_busy) begin
        if (bus.req && mq.size() < DEPTH) begin
          m_busy = 1;
          m_acc  = edge_n;
          m_d    = int'(bus.ack_delay);
        end
      end else begin
        k = edge_n - m_acc;
        if (k <= m_d && !bus.req) begin
          m_err  = 1;
          m_busy = 0;
        end else if (k == m_d + 1) begin
          if (bus.req) push = 1;
          else m_err = 1;
        end else if (k == m_d + 2) begin
          m_busy = 0;
        end
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(bus.data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", bus.ack, (m_busy && (edge_n - m_acc == m_d)) ? 1 : 0);
      check("out_valid", bus.out_valid, (mq.size() > 0) ? 1 : 0);
      check("count", bus.count, mq.size());
      check("proto_err", bus.proto_err, m_err);
      if (mq.size() > 0) check("out_data", bus.out_data, mq[0]);
    end
  end

  byte unsigned plog[$];
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) plog.push_back(bus.out_data);
  end

  task automatic start_req(input logic [7:0] d);
    bus.req  = 1'b1;
    bus.data = d;
  endtask

  task automatic wait_ack_only(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ack && lat < 100);
    check({name, " ack seen"}, bus.ack, 1);
  endtask

  task automatic wait_ack(input string name, input int exp_lat);
    int lat;
    wait_ack_only(name, lat);
    if (exp_lat >= 0) check({name, " latency"}, lat, exp_lat);
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.req = 1'b0; bus.data = '0; bus.ack_delay = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ack", bus.ack, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst count", bus.count, 0);
    check("rst proto_err", bus.proto_err, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single beat, zero delay
    start_req(8'hA5);
    wait_ack("t1", 1);
    check("t1 out_valid", bus.out_valid, 1);
    check("t1 out_data", bus.out_data, 8'hA5);
    check("t1 count", bus.count, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t1 drained", bus.count, 0);

    // Delay 3, back-to-back with drain running
    plog.delete();
    bus.ack_delay = 4'd3;
    bus.out_ready = 1'b1;
    start_req(8'h01); wait_ack("t2 b0", 4);
    start_req(8'h02); wait_ack("t2 b1", 5);
    start_req(8'h03); wait_ack("t2 b2", 5);
    repeat (3) @(negedge clk);
    check("t2 drained n", plog.size(), 3);
    for (int i = 0; i < 3 && i < plog.size(); i++) check("t2 order", plog[i], i + 1);
    check("t2 proto_err", bus.proto_err, 0);

    // Back-pressure: FIFO full withholds ack
    plog.delete();
    bus.ack_delay = 4'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_req(8'(8'h10 + i));
      wait_ack("t3 fill", (i == 0) ? 1 : 2);
    end
    start_req(8'h14);
    repeat (8) @(negedge clk);
    check("t3 full count", bus.count, 4);
    check("t3 no ack", bus.ack, 0);
    bus.out_ready = 1'b1;
    wait_ack("t3 b4", -1);
    start_req(8'h15);
    wait_ack("t3 b5", -1);
    repeat (6) @(negedge clk);
    check("t3 drained n", plog.size(), 6);
    for (int i = 0; i < 6 && i < plog.size(); i++) check("t3 order", plog[i], 8'h10 + i);

    // req dropped during WAIT
    bus.ack_delay = 4'd5;
    start_req(8'h55);
    repeat (2) @(negedge clk);
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    check("t4 proto_err", bus.proto_err, 1);
    check("t4 no push", bus.count, 0);
    repeat (6) @(negedge clk);
    check("t4 sticky", bus.proto_err, 1);
    #1 rst_n = 1'b0;
    #1 check("t4 err cleared", bus.proto_err, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset while ack is high with two entries queued
    bus.ack_delay = 4'd0;
    bus.out_ready = 1'b0;
    start_req(8'h21); wait_ack("t5 b0", 1);
    start_req(8'h22); wait_ack("t5 b1", 2);
    check("t5 count2", bus.count, 2);
    start_req(8'h23);
    wait_ack_only("t5 b2", lat);
    #1 rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check("t5 rst ack", bus.ack, 0);
    check("t5 rst out_valid", bus.out_valid, 0);
    check("t5 rst count", bus.count, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    start_req(8'h7E);
    wait_ack("t5 post", 1);
    check("t5 out_data", bus.out_data, 8'h7E);
    check("t5 count", bus.count, 1);

    // Push and pop on the same edge at count=1, across pointer wrap
    plog.delete();
    for (int i = 0; i < 10; i++) begin
      start_req(8'(8'h80 + i));
      wait_ack_only("t6", lat);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.req = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("t6 count", bus.count, 1);
    end
    check("t6 popped n", plog.size(), 10);
    if (plog.size() > 0) check("t6 first", plog[0], 8'h7E);
    for (int i = 1; i < 10 && i < plog.size(); i++) check("t6 order", plog[i], 8'h80 + i - 1);
    check("t6 head", bus.out_data, 8'h89);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
